// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite read-path definitions: FSM states, response codes and the
// grant-index width helper used by the arbiters.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int unsigned gnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester picker: round-robin after last_grant, or fixed
// priority (lowest index) when rr_mode is low.
module rr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned GNT_W   = gnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GNT_W-1:0]   last_grant,
    input  logic               rr_mode,
    output logic [GNT_W-1:0]   winner,
    output logic               has_winner
);

    logic [GNT_W-1:0] lo_idx;
    logic [GNT_W-1:0] hi_idx;
    logic             lo_found;
    logic             hi_found;

    // Round-robin = first request above last_grant, else wrap to the lowest one.
    always_comb begin
        lo_idx   = '0;
        hi_idx   = '0;
        lo_found = 1'b0;
        hi_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !lo_found) begin
                lo_idx   = GNT_W'(i);
                lo_found = 1'b1;
            end
            if (req[i] && !hi_found && (i > 32'(last_grant))) begin
                hi_idx   = GNT_W'(i);
                hi_found = 1'b1;
            end
        end
        has_winner = lo_found;
        winner     = (rr_mode && hi_found) ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/axi_lite_read_arbiter_n.sv
// Arbitrates NUM_REQ read requesters onto a single AXI4-lite read master,
// one outstanding transaction at a time.
module axi_lite_read_arbiter_n
    import axi_lite_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RR_MODE = 1,
    localparam int unsigned GNT_W  = gnt_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [GNT_W-1:0]          grant_id,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    state_t              state;
    state_t              state_next;
    logic [GNT_W-1:0]    last_grant;
    logic [GNT_W-1:0]    arb_winner;
    logic                arb_valid;
    logic [ADDR_W-1:0]   addr_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .rr_mode    (RR_MODE != 0),
        .winner     (arb_winner),
        .has_winner (arb_valid)
    );

    always_comb begin
        addr_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_winner == GNT_W'(i)) begin
                addr_sel = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs decode straight from the state so reset clears them at once.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        req_done   = '0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                busy      = 1'b1;
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                busy     = 1'b1;
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                state_next = IDLE;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    req_done[i] = (grant_id == GNT_W'(i));
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id   <= '0;
            m_araddr   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            last_grant <= GNT_W'(NUM_REQ - 1);
        end else begin
            if (state == IDLE && arb_valid) begin
                grant_id <= arb_winner;
                m_araddr <= addr_sel;
            end
            if (state == DATA && m_rvalid) begin
                rsp_data   <= m_rdata;
                rsp_err    <= (m_rresp != RESP_OKAY);
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_read_arbiter_n.sv
// Scoreboard bench: a 4-requester round-robin instance against a queue-based
// reference, plus a 2-requester fixed-priority instance on an always-ready slave.
module tb_axi_lite_read_arbiter_n;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_done;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            busy;
    logic [AW-1:0]   m_araddr;
    logic            m_arvalid;
    logic            m_arready;
    logic [DW-1:0]   m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rvalid;
    logic            m_rready;

    axi_lite_read_arbiter_n #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RR_MODE (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_done  (req_done),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .grant_id  (grant_id),
        .busy      (busy),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    logic [1:0]  f_req_valid;
    logic [63:0] f_req_addr;
    logic [1:0]  f_req_done;
    logic [31:0] f_rsp_data;
    logic        f_rsp_err;
    logic [0:0]  f_grant_id;
    logic        f_busy;
    logic [31:0] f_araddr;
    logic        f_arvalid;
    logic        f_rready;

    axi_lite_read_arbiter_n #(
        .NUM_REQ (2),
        .ADDR_W  (32),
        .DATA_W  (32),
        .RR_MODE (0)
    ) dut_fp (
        .clk       (clk),
        .rst       (rst),
        .req_valid (f_req_valid),
        .req_addr  (f_req_addr),
        .req_done  (f_req_done),
        .rsp_data  (f_rsp_data),
        .rsp_err   (f_rsp_err),
        .grant_id  (f_grant_id),
        .busy      (f_busy),
        .m_araddr  (f_araddr),
        .m_arvalid (f_arvalid),
        .m_arready (1'b1),
        .m_rdata   (32'hCAFE_0001),
        .m_rresp   (2'b00),
        .m_rvalid  (1'b1),
        .m_rready  (f_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [63:0] addr;
        logic [63:0] data;
        logic        err;
        int unsigned due;
    } exp_t;

    exp_t exp_q[$];
    int unsigned model_last = N - 1;

    // Slave behaviour knobs, set by the stimulus before each transfer.
    int unsigned ar_wait = 0;
    int unsigned r_wait  = 0;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    logic [63:0] last_ar_addr = '0;
    logic        ar_hs = 1'b0;
    bit          fp_finished = 1'b0;

    function automatic int unsigned model_pick(input logic [N-1:0] mask);
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx = (model_last + k) % N;
            if (mask[idx]) return idx;
        end
        return 0;
    endfunction

    // AXI slave model
    initial begin
        int unsigned cnt_ar;
        int unsigned cnt_r;
        bit ar_seen;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        cnt_ar = 0; cnt_r = 0; ar_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_arready = 1'b0; m_rvalid = 1'b0;
                ar_seen = 0; ar_hs = 1'b0; cnt_ar = 0; cnt_r = 0;
            end else begin
                if (m_rready) begin
                    if (cnt_r == 0) chk("rready_after_ar", ar_hs, 1);
                    m_rvalid = (cnt_r >= r_wait);
                    m_rdata  = m_rvalid ? s_rdata : {$urandom, $urandom};
                    m_rresp  = m_rvalid ? s_rresp : 2'(2'b01);
                    cnt_r++;
                    if (m_rvalid) ar_hs = 1'b0;
                end else begin
                    m_rvalid = 1'b0;
                    cnt_r = 0;
                end
                if (m_arvalid) begin
                    if (!ar_seen) begin
                        ar_seen = 1;
                        last_ar_addr = m_araddr;
                        cnt_ar = 0;
                    end else begin
                        chk("araddr_stable", m_araddr, last_ar_addr);
                    end
                    m_arready = (cnt_ar >= ar_wait);
                    cnt_ar++;
                    if (m_arready) ar_hs = 1'b1;
                end else begin
                    m_arready = 1'b0;
                    ar_seen = 0;
                end
            end
        end
    end

    // Monitor: pops one expectation per req_done pulse
    initial begin
        exp_t e;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst && req_done != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got req_done=%b expected none", req_done);
                end else begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.id] = 1'b1;
                    chk("req_done", req_done, oh);
                    chk("grant_id", grant_id, e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("araddr", last_ar_addr, e.addr);
                    chk("latency", cyc, e.due);
                end
            end
        end
    end

    task automatic rand_addrs();
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = {$urandom, $urandom} & ~64'h7;
    endtask

    // Caller is at a negedge with the DUT idle.
    task automatic do_txn(input logic [N-1:0] mask, input int unsigned arw, input int unsigned rw,
                          input logic [63:0] data, input logic [1:0] resp, input bit drop_early);
        exp_t e;
        int unsigned w;
        bit got;
        w = model_pick(mask);
        e.id   = 2'(w);
        e.addr = req_addr[w*AW +: AW];
        e.data = data;
        e.err  = (resp != 2'b00);
        e.due  = cyc + 3 + arw + rw;
        model_last = w;
        ar_wait = arw; r_wait = rw; s_rdata = data; s_rresp = resp;
        exp_q.push_back(e);
        chk("idle_before_issue", busy, 0);
        req_valid = mask;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (drop_early && k == 0) req_valid = '0;
            if (req_done != '0) got = 1;
        end
        req_valid = '0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no req_done expected one for mask %b", mask);
        end
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_arvalid"}, m_arvalid, 0);
        chk({tag, "_rready"}, m_rready, 0);
        chk({tag, "_req_done"}, req_done, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_araddr"}, m_araddr, 0);
    endtask

    // Fixed-priority instance: both requests held, index 0 always wins.
    initial begin
        int n;
        f_req_valid = '0;
        f_req_addr  = {32'h0000_2000, 32'h0000_1000};
        wait (rst);
        @(negedge clk);
        f_req_valid = 2'b11;
        n = 0;
        for (int t = 0; t < 60 && n < 3; t++) begin
            @(negedge clk);
            if (f_req_done != '0) begin
                chk("fp_done", f_req_done, 2'b01);
                chk("fp_grant", f_grant_id, 0);
                chk("fp_araddr", f_araddr, 32'h1000);
                chk("fp_busy", f_busy, 1);
                chk("fp_rready", f_rready, 0);
                n++;
            end
        end
        chk("fp_three_served", n, 3);
        f_req_valid = 2'b10;
        n = 0;
        for (int t = 0; t < 20 && n < 1; t++) begin
            @(negedge clk);
            if (f_req_done != '0) begin
                chk("fp_done_1", f_req_done, 2'b10);
                chk("fp_grant_1", f_grant_id, 1);
                chk("fp_rsp_data", f_rsp_data, 32'hCAFE_0001);
                chk("fp_rsp_err", f_rsp_err, 0);
                chk("fp_araddr_1", f_araddr, 32'h2000);
                n++;
            end
        end
        chk("fp_req1_served", n, 1);
        f_req_valid = '0;
        fp_finished = 1'b1;
    end

    initial begin
        bit seen;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b1;
        @(negedge clk);

        // Right after reset last_grant is 3: 1010 serves 1, 3, 1
        for (int i = 0; i < 3; i++) begin
            rand_addrs();
            do_txn(4'b1010, 0, 0, {$urandom, $urandom}, 2'b00, 0);
        end

        rand_addrs();
        req_addr[0 +: AW] = 64'h8000_0000;
        do_txn(4'b0001, 0, 0, 64'hDEAD_BEEF_0000_0013, 2'b00, 0);

        for (int i = 0; i < 4; i++) begin
            rand_addrs();
            do_txn(4'b0011, 0, 0, {$urandom, $urandom}, 2'b00, 0);
        end

        rand_addrs();
        do_txn(4'b0001, 5, 0, {$urandom, $urandom}, 2'b00, 0);

        rand_addrs();
        do_txn(4'b0010, 0, 0, 64'h1234, 2'b10, 0);
        do_txn(4'b0010, 0, 0, 64'h5678, 2'b00, 0);
        do_txn(4'b0100, 1, 2, 64'h9ABC, 2'b11, 0);

        for (int i = 0; i < 60; i++) begin
            logic [N-1:0] m;
            m = 4'($urandom_range(1, 15));
            rand_addrs();
            do_txn(m, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
                   2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        for (int t = 0; t < 200 && !fp_finished; t++) @(negedge clk);
        chk("fp_finished", fp_finished, 1);

        // Reset while the R channel is open
        rand_addrs();
        ar_wait = 0;
        r_wait  = 40;
        req_valid = 4'b0100;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (m_rready) seen = 1;
        end
        chk("rready_reached", seen, 1);
        #2 rst = 1'b0;
        req_valid = '0;
        #1 chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r_wait = 0;
        model_last = N - 1;
        repeat (3) @(negedge clk);
        chk("no_stale_done", req_done, 0);
        chk("idle_after_rst", busy, 0);
        rand_addrs();
        do_txn(4'b1111, 0, 0, {$urandom, $urandom}, 2'b00, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected $finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_read_arbiter_n.md
Name: axi_lite_read_arbiter_n

Overview:
- Parametrised successor to the two-port instruction/execute read arbiter: arbitrates NUM_REQ read requesters (IFU, MEM, future DMA/debug) onto one AXI4-lite read master (AR + R channels).
- Adds selectable fixed or round-robin priority, a full valid/ready handshake toward memory, error response forwarding, and a grant-id output.
- Sits between the core's fetch/load units and the memory-side AXI4-lite slave; the write path is untouched.

Parameters:
- NUM_REQ, 2, number of requesters (1..8); index 0 is IFU by convention.
- ADDR_W, 64, address width.
- DATA_W, 64, read data width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester level request; held until its req_done.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i = requester i; stable while req_valid[i].
- req_done  out  NUM_REQ  one-cycle pulse to the served requester; rsp_* valid in the same cycle.
- rsp_data  out  DATA_W  read data, shared by all requesters, held until the next completion.
- rsp_err  out  1  1 when the completed transfer's rresp != OKAY; qualified by req_done.
- grant_id  out  GNT_W=max(1,$clog2(NUM_REQ))  index of the current or last-served requester.
- busy  out  1  high in any state other than IDLE.
- m_araddr  out  ADDR_W  AXI read address.
- m_arvalid  out  1  AXI AR valid.
- m_arready  in  1  AXI AR ready.
- m_rdata  in  DATA_W  AXI read data.
- m_rresp  in  2  AXI read response.
- m_rvalid  in  1  AXI R valid.
- m_rready  out  1  AXI R ready.

Behaviour:
- Reset: rst low forces state IDLE and all outputs to 0 immediately, including an in-flight m_arvalid. last_grant resets to NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - If any req_valid is set, choose the winner i.
  - RR_MODE=1: first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - RR_MODE=0: lowest set index.
  - Register grant_id=i, m_araddr=req_addr[i] and m_arvalid=1, then go to ADDR.
- ADDR: hold m_arvalid and m_araddr stable until m_arready=1. On that edge drop m_arvalid, set m_rready=1 and go to DATA. m_rvalid is ignored in ADDR.
- DATA: wait for m_rvalid. On the m_rvalid & m_rready edge:
  - capture m_rdata into rsp_data;
  - set rsp_err=(m_rresp!=2'b00);
  - set m_rready=0 and req_done[grant_id]=1;
  - last_grant=grant_id;
  - go to DONE.
- DONE: single cycle. req_done clears on exit; return to IDLE. req_valid is not sampled in DONE.
- Requester contract: the served requester deasserts req_valid in the cycle after its req_done (the DONE cycle). A request still high in IDLE after that is treated as a new request.
- Latency with a zero-wait slave (arready high, rvalid one cycle after AR): req_valid seen in cycle 0, arvalid in cycle 1, rready in cycle 2, req_done in cycle 3. Back-to-back service interval is 4 cycles.
- A requester dropping req_valid mid-transaction does not abort it: the transfer completes and the req_done pulse is still issued.
- grant_id and rsp_data hold their last value in IDLE; rsp_err is meaningful only with req_done.
- NUM_REQ=1 degenerates to a pass-through FSM; grant_id is held at 0.
- m_rvalid arriving while m_rready=0 is never consumed. AXI4-lite forbids R before the AR handshake, so no hazard arises.
- Exactly one transaction is outstanding at a time; no reordering.

Decomposition:
- Shared package axi_lite_pkg:
  - state enum {IDLE, ADDR, DATA, DONE};
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - GNT_W helper function.
- Sub-module rr_arbiter:
  - input: request vector, last_grant and mode;
  - output: winner index plus a has-winner flag;
  - combinational, reusable by the future write arbiter.

Test Plan:
- Single requester: req_valid=2'b01, addr 0x8000_0000, zero-wait slave returning 0xDEAD_BEEF_0000_0013 -> arvalid in cycle 1 with that address; req_done=2'b01 in cycle 3; rsp_data matches; rsp_err=0.
- Simultaneous requests, RR_MODE=1: req_valid=2'b11 held continuously (re-raised after each done) -> grant order 0,1,0,1. In RR_MODE=0 the grant order is 0,0,0.
- AR backpressure: arready low for 5 cycles -> arvalid and araddr stable throughout; no rready before the AR handshake; req_done at cycle 3+5.
- Error response: rresp=2'b10 returning 0x1234 -> req_done pulse with rsp_err=1 and rsp_data=0x1234. The next OKAY transfer gives rsp_err=0.
- Reset in DATA: assert rst low while rready=1 -> all outputs 0 asynchronously. After release, requester 0 wins first; no stale req_done appears.
- NUM_REQ=4, RR_MODE=1, last_grant=3, req_valid=4'b1010 -> grant 1, then 3, then 1.
